// File: rtl/stack_cpu_pkg.sv
// Shared definitions for the stack CPU controller: opcodes, datapath select
// codes, fault codes, FSM state encoding and small opcode-class helpers.
package stack_cpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_PUSH = 4'd6;
  localparam logic [3:0] OP_POP  = 4'd7;
  localparam logic [3:0] OP_JMP  = 4'd8;
  localparam logic [3:0] OP_JZ   = 4'd9;
  localparam logic [3:0] OP_DUP  = 4'd10;
  localparam logic [3:0] OP_HALT = 4'd15;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOT = 3'b101;

  localparam logic [1:0] DIN_MEM = 2'b00;
  localparam logic [1:0] DIN_ALU = 2'b01;
  localparam logic [1:0] DIN_TOS = 2'b10;

  localparam logic [1:0] SRCA_A   = 2'b00;
  localparam logic [1:0] SRCA_PC  = 2'b01;
  localparam logic [1:0] SRCA_TOS = 2'b10;

  localparam logic SRCB_B   = 1'b0;
  localparam logic SRCB_ONE = 1'b1;

  localparam logic [2:0] FAULT_NONE    = 3'b000;
  localparam logic [2:0] FAULT_UNDER   = 3'b001;
  localparam logic [2:0] FAULT_OVER    = 3'b010;
  localparam logic [2:0] FAULT_ILLEGAL = 3'b011;
  localparam logic [2:0] FAULT_TIMEOUT = 3'b100;

  typedef enum logic [3:0] {
    S_IF    = 4'd0,
    S_ID    = 4'd1,
    S_BOP1  = 4'd2,
    S_BOP2  = 4'd3,
    S_UOP   = 4'd4,
    S_WB    = 4'd5,
    S_MRD   = 4'd6,
    S_MWR   = 4'd7,
    S_JMP   = 4'd8,
    S_JZ    = 4'd9,
    S_DUP   = 4'd10,
    S_HALT  = 4'd11,
    S_FAULT = 4'd12
  } state_t;

  // Opcodes 11..14 are unassigned in this instruction set.
  function automatic logic op_illegal(input logic [3:0] op);
    return (op >= 4'd11) && (op <= 4'd14);
  endfunction

  // Binary ALU ops consume two operands.
  function automatic logic op_needs_two(input logic [3:0] op);
    return op <= OP_XOR;
  endfunction

  // Ops that read the top of stack and therefore need at least one entry.
  function automatic logic op_needs_one(input logic [3:0] op);
    return (op == OP_NOT) || (op == OP_POP) || (op == OP_JZ) || (op == OP_DUP);
  endfunction

  // Ops that add an entry without first removing one.
  function automatic logic op_grows(input logic [3:0] op);
    return (op == OP_PUSH) || (op == OP_DUP);
  endfunction

endpackage

// File: rtl/stack_depth_tracker.sv
// Stack occupancy counter driven by the controller's push/pop strobes.
// Flags are decoded from the registered count so they are stable for the
// whole decode cycle.
module stack_depth_tracker #(
  parameter int unsigned STACK_DEPTH = 16,
  parameter int unsigned DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  logic               i_pop,
  output logic [DEPTH_W-1:0] o_depth,
  output logic               o_empty,
  output logic               o_full,
  output logic               o_ge2
);

  logic [DEPTH_W-1:0] r_depth;

  // Count up on push, down on pop; simultaneous strobes cancel.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_depth <= '0;
    end else if (i_push && !i_pop) begin
      r_depth <= r_depth + 1'b1;
    end else if (i_pop && !i_push) begin
      r_depth <= r_depth - 1'b1;
    end
  end

  assign o_depth = r_depth;
  assign o_empty = (r_depth == '0);
  assign o_full  = (r_depth >= DEPTH_W'(STACK_DEPTH));
  assign o_ge2   = (r_depth >= DEPTH_W'(2));

endmodule

// File: rtl/stack_cpu_ctrl_v2.sv
// Multi-cycle control FSM for the stack CPU. Sequences fetch, decode and
// execute, keeps the stack depth, checks operand preconditions at decode,
// and watches the memory handshake for a stuck ready.
//
//   state | meaning
//   IF    | fetch instruction, PC <= PC + 1 when memory returns
//   ID    | decode, precondition checks, dispatch
//   BOP1  | pop B operand
//   BOP2  | pop A operand, ALU computes op
//   UOP   | ALU computes NOT of TOS
//   WB    | push ALU result
//   MRD   | read memory at IR address, push on ready
//   MWR   | write TOS to memory at IR address, pop on ready
//   JMP   | PC <= IR address
//   JZ    | pop TOS, PC <= IR address if zero
//   DUP   | push copy of TOS
//   HALT  | stopped, waits for reset
//   FAULT | stopped with fault code latched, waits for reset
module stack_cpu_ctrl_v2
  import stack_cpu_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = 16,
  parameter int unsigned DEPTH_W     = $clog2(STACK_DEPTH + 1),
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_src,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               ad_select,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         din_sel,
  output logic [1:0]         alu_src_a,
  output logic               alu_src_b,
  output logic [2:0]         alu_op,
  output logic               push,
  output logic               pop,
  output logic               tos,
  output logic [DEPTH_W-1:0] depth,
  output logic               halted,
  output logic [2:0]         fault
);

  // Wait counter holds 0..MEM_TIMEOUT-1; a 1-bit floor keeps it legal when
  // the timeout is tiny or disabled.
  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_TC =
    WAIT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_t            r_state;
  state_t            w_next;
  logic [2:0]        r_fault;
  logic [2:0]        w_fault_code;
  logic [WAIT_W-1:0] r_wait;
  logic              w_mem_req;
  logic              w_wait;
  logic              w_timeout;
  logic              w_empty;
  logic              w_full;
  logic              w_ge2;

  stack_depth_tracker #(
    .STACK_DEPTH (STACK_DEPTH),
    .DEPTH_W     (DEPTH_W)
  ) u_depth (
    .clk     (clk),
    .rst     (rst),
    .i_push  (push),
    .i_pop   (pop),
    .o_depth (depth),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_ge2   (w_ge2)
  );

  // A memory request is outstanding in every state that drives mem_read or
  // mem_write; derived from state only so the timer has no comb loop.
  assign w_mem_req = (r_state == S_IF) || (r_state == S_MRD) || (r_state == S_MWR);
  assign w_wait    = w_mem_req && !mem_ready;
  assign w_timeout = (MEM_TIMEOUT != 0) && w_wait && (r_wait == WAIT_TC);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IF;
    end else begin
      r_state <= w_next;
    end
  end

  // Memory wait timer: counts stalled request cycles within one state.
  always_ff @(posedge clk) begin
    if (!rst || !w_wait || (w_next != r_state)) begin
      r_wait <= '0;
    end else begin
      r_wait <= r_wait + 1'b1;
    end
  end

  // Fault code is captured on entry to FAULT and held until reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fault <= FAULT_NONE;
    end else if ((r_state != S_FAULT) && (w_next == S_FAULT)) begin
      r_fault <= w_fault_code;
    end
  end

  assign fault = r_fault;

  // Next-state and control decode.
  always_comb begin
    w_next        = r_state;
    w_fault_code  = FAULT_NONE;
    pc_src        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ad_select     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    din_sel       = DIN_MEM;
    alu_src_a     = SRCA_A;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    push          = 1'b0;
    pop           = 1'b0;
    tos           = 1'b0;
    halted        = 1'b0;

    case (r_state)
      S_IF: begin
        mem_read  = 1'b1;
        alu_src_a = SRCA_PC;
        alu_src_b = SRCB_ONE;
        alu_op    = ALU_ADD;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = S_ID;
        end
      end

      S_ID: begin
        tos = 1'b1;
        if (op_illegal(opcode)) begin
          w_next       = S_FAULT;
          w_fault_code = FAULT_ILLEGAL;
        end else if ((op_needs_two(opcode) && !w_ge2) ||
                     (op_needs_one(opcode) && w_empty)) begin
          w_next       = S_FAULT;
          w_fault_code = FAULT_UNDER;
        end else if (op_grows(opcode) && w_full) begin
          w_next       = S_FAULT;
          w_fault_code = FAULT_OVER;
        end else begin
          case (opcode)
            OP_NOT:  w_next = S_UOP;
            OP_PUSH: w_next = S_MRD;
            OP_POP:  w_next = S_MWR;
            OP_JMP:  w_next = S_JMP;
            OP_JZ:   w_next = S_JZ;
            OP_DUP:  w_next = S_DUP;
            OP_HALT: w_next = S_HALT;
            default: w_next = S_BOP1;
          endcase
        end
      end

      S_BOP1: begin
        pop    = 1'b1;
        w_next = S_BOP2;
      end

      S_BOP2: begin
        pop       = 1'b1;
        alu_src_a = SRCA_TOS;
        alu_src_b = SRCB_B;
        alu_op    = opcode[2:0];
        w_next    = S_WB;
      end

      S_UOP: begin
        alu_src_a = SRCA_TOS;
        alu_op    = ALU_NOT;
        w_next    = S_WB;
      end

      S_WB: begin
        push    = 1'b1;
        din_sel = DIN_ALU;
        w_next  = S_IF;
      end

      S_MRD: begin
        mem_read  = 1'b1;
        ad_select = 1'b1;
        if (mem_ready) begin
          push    = 1'b1;
          din_sel = DIN_MEM;
          w_next  = S_IF;
        end
      end

      S_MWR: begin
        mem_write = 1'b1;
        ad_select = 1'b1;
        if (mem_ready) begin
          pop    = 1'b1;
          w_next = S_IF;
        end
      end

      S_JMP: begin
        pc_src   = 1'b1;
        pc_write = 1'b1;
        w_next   = S_IF;
      end

      S_JZ: begin
        pop           = 1'b1;
        alu_src_a     = SRCA_TOS;
        alu_op        = ALU_ADD;
        pc_src        = 1'b1;
        pc_write_cond = 1'b1;
        w_next        = S_IF;
      end

      S_DUP: begin
        push    = 1'b1;
        din_sel = DIN_TOS;
        w_next  = S_IF;
      end

      S_HALT: begin
        halted = 1'b1;
      end

      S_FAULT: begin
        halted = 1'b1;
      end

      default: begin
        w_next = S_IF;
      end
    endcase

    // A stalled request overrides the normal transition; ready is low in
    // that cycle so no handshaked strobe fires.
    if (w_timeout) begin
      w_next       = S_FAULT;
      w_fault_code = FAULT_TIMEOUT;
    end
  end

endmodule
